image_bank_ctrl: RTL and testbench

- Scheduler for the two ping-pong image memory banks (m0/m1) inside the image block.
- Grants a free bank to the image loader and a full bank to the convolution reader, and tracks bank ownership.
- Issues the matching CFG_IMG_WR / CFG_IMG_RD writes on the shared config bus, so the image block selects the correct bank.
- Supports re-reading one loaded image a programmable number of times before the bank is released.

---
 rtl/image_bank_ctrl_pkg.sv | 16 +
 rtl/image_bank_state.sv | 39 +++
 rtl/image_bank_ctrl.sv | 116 +++++++++++
 tb/tb_image_bank_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/image_bank_ctrl_pkg.sv
// Shared definitions for the image bank scheduler: bank-state encoding and
// the config-bus register addresses of the image block.
package image_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Must track the addresses defined in cfg_parameters.vh.
  localparam int CFG_IMG_WR = 6;
  localparam int CFG_IMG_RD = 7;

endpackage

// File: rtl/image_bank_state.sv
// Per-bank ownership tracker: EMPTY -> FILLING -> FULL <-> READING -> EMPTY.
// The full flag covers FULL and READING (image present, not yet released).
module image_bank_state
  import image_bank_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fill_start,
  input  logic        i_fill_done,
  input  logic        i_read_start,
  input  logic        i_read_done,
  input  logic        i_release,
  output bank_state_e o_state,
  output logic        o_full
);

  bank_state_e r_state;
  bank_state_e w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BANK_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      BANK_EMPTY:   if (i_fill_start) w_next = BANK_FILLING;
      BANK_FILLING: if (i_fill_done)  w_next = BANK_FULL;
      BANK_FULL:    if (i_read_start) w_next = BANK_READING;
      BANK_READING: if (i_read_done)  w_next = i_release ? BANK_EMPTY : BANK_FULL;
      default:      w_next = BANK_EMPTY;
    endcase
  end

  assign o_state = r_state;
  assign o_full  = (r_state == BANK_FULL) || (r_state == BANK_READING);

endmodule

// File: rtl/image_bank_ctrl.sv
// Ping-pong bank scheduler: grants banks to loader and reader in load order
// and writes the selected bank to the image block over the config bus.
module image_bank_ctrl
  import image_bank_ctrl_pkg::*;
#(
  parameter int CFG_DWIDTH   = 32,
  parameter int CFG_AWIDTH   = 5,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_start_val,
  output logic                    wr_start_rdy,
  input  logic                    wr_done,
  input  logic                    rd_start_val,
  output logic                    rd_start_rdy,
  input  logic                    rd_done,
  input  logic [REPEAT_WIDTH-1:0] repeat_nb,
  output logic [CFG_DWIDTH-1:0]   cfg_data,
  output logic [CFG_AWIDTH-1:0]   cfg_addr,
  output logic                    cfg_valid,
  output logic                    wr_bank,
  output logic                    rd_bank,
  output logic [1:0]              bank_full,
  output logic                    err
);

  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic                    r_fill_act;
  logic                    r_read_act;
  logic [REPEAT_WIDTH-1:0] r_remain;

  bank_state_e w_state [2];
  logic        w_wr_grant;
  logic        w_rd_grant;
  logic        w_fill_fin;
  logic        w_read_fin;
  logic        w_last_pass;

  assign wr_start_rdy = !r_fill_act && (w_state[r_wr_ptr] == BANK_EMPTY);
  assign w_wr_grant   = wr_start_val && wr_start_rdy;
  // Write grant wins: the config bus carries only one write per cycle.
  assign rd_start_rdy = !r_read_act && (w_state[r_rd_ptr] == BANK_FULL) && !w_wr_grant;
  assign w_rd_grant   = rd_start_val && rd_start_rdy;

  assign w_fill_fin  = wr_done && r_fill_act;
  assign w_read_fin  = rd_done && r_read_act;
  assign w_last_pass = (r_remain <= REPEAT_WIDTH'(1));

  for (genvar g = 0; g < 2; g++) begin : g_bank
    image_bank_state u_bank (
      .clk          (clk),
      .rst          (rst),
      .i_fill_start (w_wr_grant && (r_wr_ptr == 1'(g))),
      .i_fill_done  (w_fill_fin && (r_wr_ptr == 1'(g))),
      .i_read_start (w_rd_grant && (r_rd_ptr == 1'(g))),
      .i_read_done  (w_read_fin && (r_rd_ptr == 1'(g))),
      .i_release    (w_last_pass),
      .o_state      (w_state[g]),
      .o_full       (bank_full[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fill_act <= 1'b0;
      r_read_act <= 1'b0;
      r_remain   <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (w_wr_grant) begin
        r_fill_act <= 1'b1;
        wr_bank    <= r_wr_ptr;
      end else if (w_fill_fin) begin
        r_fill_act <= 1'b0;
        r_wr_ptr   <= !r_wr_ptr;
      end
      if (w_rd_grant) begin
        r_read_act <= 1'b1;
        rd_bank    <= r_rd_ptr;
        // Pass count is loaded only on the first grant of a freshly loaded image.
        if (r_remain == '0)
          r_remain <= (repeat_nb == '0) ? REPEAT_WIDTH'(1) : repeat_nb;
      end else if (w_read_fin) begin
        r_read_act <= 1'b0;
        r_remain   <= r_remain - REPEAT_WIDTH'(1);
        if (w_last_pass) r_rd_ptr <= !r_rd_ptr;
      end
      if ((wr_done && !r_fill_act) || (rd_done && !r_read_act))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
    end else begin
      cfg_valid <= w_wr_grant || w_rd_grant;
      if (w_wr_grant) begin
        cfg_addr <= CFG_AWIDTH'(CFG_IMG_WR);
        cfg_data <= CFG_DWIDTH'(r_wr_ptr);
      end else if (w_rd_grant) begin
        cfg_addr <= CFG_AWIDTH'(CFG_IMG_RD);
        cfg_data <= CFG_DWIDTH'(r_rd_ptr);
      end
    end
  end

endmodule

// File: tb/tb_image_bank_ctrl.sv
// Directed table-driven bench for image_bank_ctrl, plus hand-written
// error, repeat and mid-operation reset sequences.
module tb_image_bank_ctrl;
  import image_bank_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_start_val = 1'b0;
  logic        wr_start_rdy;
  logic        wr_done = 1'b0;
  logic        rd_start_val = 1'b0;
  logic        rd_start_rdy;
  logic        rd_done = 1'b0;
  logic [7:0]  repeat_nb = 8'd1;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic        wr_bank;
  logic        rd_bank;
  logic [1:0]  bank_full;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  image_bank_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_start_val (wr_start_val),
    .wr_start_rdy (wr_start_rdy),
    .wr_done      (wr_done),
    .rd_start_val (rd_start_val),
    .rd_start_rdy (rd_start_rdy),
    .rd_done      (rd_done),
    .repeat_nb    (repeat_nb),
    .cfg_data     (cfg_data),
    .cfg_addr     (cfg_addr),
    .cfg_valid    (cfg_valid),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .bank_full    (bank_full),
    .err          (err)
  );

  typedef struct {
    logic       wv, wd, rv, rd;
    logic [7:0] rep;
    logic       pwr, prd;
    logic       cv;
    logic [4:0] ca;
    logic       cd;
    logic       wb, rb;
    logic [1:0] full;
    logic       e;
  } vec_t;

  function automatic vec_t mk(input logic wv, wd, rv, rd, input int rep,
                              input logic pwr, prd, cv, input int ca,
                              input logic cd, wb, rb, input logic [1:0] full,
                              input logic e);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rv = rv; v.rd = rd; v.rep = 8'(rep);
    v.pwr = pwr; v.prd = prd; v.cv = cv; v.ca = 5'(ca); v.cd = cd;
    v.wb = wb; v.rb = rb; v.full = full; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    wr_start_val = v.wv; wr_done = v.wd;
    rd_start_val = v.rv; rd_done = v.rd;
    repeat_nb    = v.rep;
    #1;
    chk({tag, ".wr_start_rdy"}, 32'(wr_start_rdy), 32'(v.pwr));
    chk({tag, ".rd_start_rdy"}, 32'(rd_start_rdy), 32'(v.prd));
    @(posedge clk);
    #1;
    chk({tag, ".cfg_valid"}, 32'(cfg_valid), 32'(v.cv));
    chk({tag, ".cfg_addr"},  32'(cfg_addr),  32'(v.ca));
    chk({tag, ".cfg_data"},  cfg_data,       {31'b0, v.cd});
    chk({tag, ".wr_bank"},   32'(wr_bank),   32'(v.wb));
    chk({tag, ".rd_bank"},   32'(rd_bank),   32'(v.rb));
    chk({tag, ".bank_full"}, 32'(bank_full), 32'(v.full));
    chk({tag, ".err"},       32'(err),       32'(v.e));
  endtask

  localparam int W = CFG_IMG_WR;
  localparam int R = CFG_IMG_RD;

  vec_t tbl [22];
  vec_t hs  [10];

  initial begin
    tbl[0]  = mk(0,0,0,0,1, 1,0, 0,0,0,0,0,2'b00,0);
    tbl[1]  = mk(1,0,0,0,1, 1,0, 1,W,0,0,0,2'b00,0);
    tbl[2]  = mk(0,0,0,0,1, 0,0, 0,W,0,0,0,2'b00,0);
    tbl[3]  = mk(0,1,0,0,1, 0,0, 0,W,0,0,0,2'b01,0);
    tbl[4]  = mk(1,0,1,0,1, 1,0, 1,W,1,1,0,2'b01,0);
    tbl[5]  = mk(0,0,1,0,1, 0,1, 1,R,0,1,0,2'b01,0);
    tbl[6]  = mk(0,1,0,0,1, 0,0, 0,R,0,1,0,2'b11,0);
    tbl[7]  = mk(1,0,0,1,1, 0,0, 0,R,0,1,0,2'b10,0);
    tbl[8]  = mk(1,0,0,0,1, 1,0, 1,W,0,0,0,2'b10,0);
    tbl[9]  = mk(0,0,1,0,1, 0,1, 1,R,1,0,1,2'b10,0);
    tbl[10] = mk(0,1,0,1,1, 0,0, 0,R,1,0,1,2'b01,0);
    tbl[11] = mk(0,0,0,0,1, 1,1, 0,R,1,0,1,2'b01,0);
    tbl[12] = mk(0,0,1,0,3, 1,1, 1,R,0,0,0,2'b01,0);
    tbl[13] = mk(0,0,0,1,3, 1,0, 0,R,0,0,0,2'b01,0);
    tbl[14] = mk(0,0,1,0,3, 1,1, 1,R,0,0,0,2'b01,0);
    tbl[15] = mk(0,0,0,1,3, 1,0, 0,R,0,0,0,2'b01,0);
    tbl[16] = mk(0,0,1,0,3, 1,1, 1,R,0,0,0,2'b01,0);
    tbl[17] = mk(1,0,0,1,3, 1,0, 1,W,1,1,0,2'b00,0);
    tbl[18] = mk(0,1,1,0,1, 0,0, 0,W,1,1,0,2'b10,0);
    tbl[19] = mk(0,0,1,0,1, 1,1, 1,R,1,1,1,2'b10,0);
    tbl[20] = mk(0,1,0,0,1, 1,0, 0,R,1,1,1,2'b10,1);
    tbl[21] = mk(0,0,0,0,1, 1,0, 0,R,1,1,1,2'b10,1);

    hs[0] = mk(0,0,0,1,1, 1,0, 0,0,0,0,0,2'b00,1);
    hs[1] = mk(0,1,0,0,1, 1,0, 0,0,0,0,0,2'b00,1);
    hs[2] = mk(1,0,0,0,1, 1,0, 1,W,0,0,0,2'b00,1);
    hs[3] = mk(0,1,0,0,1, 0,0, 0,W,0,0,0,2'b01,1);
    hs[4] = mk(1,0,0,0,1, 1,0, 1,W,1,1,0,2'b01,1);
    hs[5] = mk(0,1,0,0,1, 0,1, 0,W,1,1,0,2'b11,1);
    hs[6] = mk(0,0,1,0,1, 0,1, 1,R,0,1,0,2'b11,1);
    hs[7] = mk(0,0,0,1,1, 0,0, 0,R,0,1,0,2'b10,1);
    hs[8] = mk(0,0,1,0,1, 1,1, 1,R,1,1,1,2'b10,1);
    hs[9] = mk(1,0,0,0,1, 1,0, 1,W,0,0,0,2'b00,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Fresh reset, then protocol errors and a fill/read run up to bank1 READING.
    @(negedge clk);
    wr_start_val = 0; wr_done = 0; rd_start_val = 0; rd_done = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step($sformatf("seq%0d", i), hs[i]);

    // Asynchronous reset while cfg_valid is high and bank1 is READING.
    #1 rst = 1'b1;
    #1;
    chk("arst.cfg_valid",    32'(cfg_valid),    32'd0);
    chk("arst.cfg_addr",     32'(cfg_addr),     32'd0);
    chk("arst.cfg_data",     cfg_data,          32'd0);
    chk("arst.wr_bank",      32'(wr_bank),      32'd0);
    chk("arst.rd_bank",      32'(rd_bank),      32'd0);
    chk("arst.bank_full",    32'(bank_full),    32'd0);
    chk("arst.err",          32'(err),          32'd0);
    chk("arst.rd_start_rdy", 32'(rd_start_rdy), 32'd0);
    chk("arst.wr_start_rdy", 32'(wr_start_rdy), 32'd1);
    wr_start_val = 0; wr_done = 0; rd_start_val = 0; rd_done = 0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", hs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
